// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if
//   Bundles the two requester channels and the ALU side of alu_arbiter.
//   slave  : the arbiter's view (requests/operands/alu_in in, grants,
//            completions, result and ALU drive out).
//   master : the environment's view (requesters plus the alu16 datapath).
//   Signals:
//     req0/req1, fs0/fs1, a0/b0/a1/b1 : requester inputs
//     gnt0/gnt1, done0/done1          : one-cycle grant / completion pulses
//     res, busy                       : registered result, not-idle flag
//     alu_a, alu_b, alufs, alu_clr    : drive to the ALU
//     alu_in                          : combinational ALU result
interface alu_arbiter_if #(
   parameter int WIDTH = 16
);
   logic             req0;
   logic             req1;
   logic [1:0]       fs0;
   logic [1:0]       fs1;
   logic [WIDTH-1:0] a0;
   logic [WIDTH-1:0] b0;
   logic [WIDTH-1:0] a1;
   logic [WIDTH-1:0] b1;
   logic             gnt0;
   logic             gnt1;
   logic             done0;
   logic             done1;
   logic [WIDTH-1:0] res;
   logic             busy;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [1:0]       alufs;
   logic             alu_clr;
   logic [WIDTH-1:0] alu_in;

   modport slave (
      input  req0, req1, fs0, fs1, a0, b0, a1, b1, alu_in,
      output gnt0, gnt1, done0, done1, res, busy,
             alu_a, alu_b, alufs, alu_clr
   );

   modport master (
      output req0, req1, fs0, fs1, a0, b0, a1, b1, alu_in,
      input  gnt0, gnt1, done0, done1, res, busy,
             alu_a, alu_b, alufs, alu_clr
   );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one combinational alu16 between two requesters. Each operation
//   takes a fixed IDLE -> ISSUE -> WB walk: operands are captured on the
//   grant, the ALU result is latched into res at the end of ISSUE, and the
//   winner sees done in WB. Ties alternate through a round-robin pointer.
//   Ports:
//     clk       : clock, rising edge
//     reset     : asynchronous, active-low
//     bus       : alu_arbiter_if.slave (requesters + ALU)
//     state_dbg : current FSM state (0=IDLE, 1=ISSUE, 2=WB)
//   WIDTH must be 16 to match the alu16 datapath.
//
// Handshake: a requester holds reqN with its fsN/aN/bN stable; the
// arbiter samples requests only in IDLE. gntN pulses for one cycle when
// the operands have been captured, after which the requester may drop
// reqN and change operands. doneN pulses for one cycle two cycles after
// the sampling edge; res is valid in that cycle and held afterwards.
// Requests seen outside IDLE are not remembered.
module alu_arbiter #(
   parameter int WIDTH = 16
) (
   input  logic              clk,
   input  logic              reset,
   alu_arbiter_if.slave      bus,
   output logic [1:0]        state_dbg
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WB    = 2'd2
   } state_t;

   state_t           state;
   logic             prio;      // requester favoured on a tie
   logic             win;       // requester owning the in-flight op
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [1:0]       op_fs;
   logic [WIDTH-1:0] res_q;
   logic             gnt0_q;
   logic             gnt1_q;
   logic             done0_q;
   logic             done1_q;
   logic             busy_q;
   logic             clr_q;
   logic             pick1;

   // Requester 1 wins when it is alone, or when both ask and it holds priority.
   always_comb begin
      pick1 = bus.req1 & (~bus.req0 | prio);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         prio    <= 1'b0;
         win     <= 1'b0;
         op_a    <= '0;
         op_b    <= '0;
         op_fs   <= 2'b00;
         res_q   <= '0;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
         busy_q  <= 1'b0;
         clr_q   <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req0 | bus.req1) begin
                  state  <= ISSUE;
                  win    <= pick1;
                  op_a   <= pick1 ? bus.a1  : bus.a0;
                  op_b   <= pick1 ? bus.b1  : bus.b0;
                  op_fs  <= pick1 ? bus.fs1 : bus.fs0;
                  gnt0_q <= ~pick1;
                  gnt1_q <= pick1;
                  busy_q <= 1'b1;
                  clr_q  <= 1'b0;   // release the ALU only for ISSUE
               end
            end
            ISSUE: begin
               state   <= WB;
               res_q   <= bus.alu_in;
               gnt0_q  <= 1'b0;
               gnt1_q  <= 1'b0;
               done0_q <= ~win;
               done1_q <= win;
               clr_q   <= 1'b1;
            end
            WB: begin
               state   <= IDLE;
               done0_q <= 1'b0;
               done1_q <= 1'b0;
               busy_q  <= 1'b0;
               prio    <= ~win;     // loser of this round wins the next tie
            end
            default: begin
               state   <= IDLE;
               gnt0_q  <= 1'b0;
               gnt1_q  <= 1'b0;
               done0_q <= 1'b0;
               done1_q <= 1'b0;
               busy_q  <= 1'b0;
               clr_q   <= 1'b1;
            end
         endcase
      end
   end

   // Operand registers feed the ALU in every state; alu_clr keeps its
   // output at zero except during ISSUE.
   assign bus.alu_a   = op_a;
   assign bus.alu_b   = op_b;
   assign bus.alufs   = op_fs;
   assign bus.alu_clr = clr_q;
   assign bus.res     = res_q;
   assign bus.gnt0    = gnt0_q;
   assign bus.gnt1    = gnt1_q;
   assign bus.done0   = done0_q;
   assign bus.done1   = done1_q;
   assign bus.busy    = busy_q;
   assign state_dbg   = state;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
//   Directed bench for alu_arbiter: drives both requesters, models the
//   alu16 datapath on the ALU side and checks grants, completions and
//   results against hand-computed values.
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  state_dbg;
   int          checks = 0;
   int          errors = 0;

   alu_arbiter_if #(.WIDTH(16)) bus ();

   alu_arbiter #(.WIDTH(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;

   // alu16: 00=b, 01=b+1, 10=a+b, 11=a-b; clear forces zero.
   function automatic logic [15:0] alu16(input logic [1:0] fs,
                                         input logic [15:0] a,
                                         input logic [15:0] b);
      case (fs)
         2'b00:   return b;
         2'b01:   return b + 16'd1;
         2'b10:   return a + b;
         default: return a - b;
      endcase
   endfunction

   assign bus.alu_in = bus.alu_clr ? 16'h0000 : alu16(bus.alufs, bus.alu_a, bus.alu_b);

   // Observations captured by issue_op.
   logic        o_gnt0, o_gnt1, o_busy1, o_clr1;
   logic [15:0] o_alu_a, o_alu_b;
   logic [1:0]  o_alufs, o_state1;
   logic        o_done0, o_done1, o_busy2;
   logic [15:0] o_res;
   logic        o_done0_n, o_done1_n, o_busy_n;

   // Presents one request in an IDLE cycle and records the ISSUE, WB and
   // following cycle.
   task automatic issue_op(input bit who, input logic [1:0] fs,
                           input logic [15:0] a, input logic [15:0] b);
      if (!who) begin
         bus.req0 = 1'b1; bus.fs0 = fs; bus.a0 = a; bus.b0 = b;
      end else begin
         bus.req1 = 1'b1; bus.fs1 = fs; bus.a1 = a; bus.b1 = b;
      end
      @(posedge clk);
      @(negedge clk);
      o_gnt0 = bus.gnt0;  o_gnt1 = bus.gnt1;  o_busy1 = bus.busy;
      o_clr1 = bus.alu_clr; o_alu_a = bus.alu_a; o_alu_b = bus.alu_b;
      o_alufs = bus.alufs; o_state1 = state_dbg;
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      @(negedge clk);
      o_done0 = bus.done0; o_done1 = bus.done1; o_busy2 = bus.busy; o_res = bus.res;
      @(negedge clk);
      o_done0_n = bus.done0; o_done1_n = bus.done1; o_busy_n = bus.busy;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1} !== 4'b0000) begin
         errors++; $display("FAIL reset_pulses got=%b exp=0000", {bus.gnt0, bus.gnt1, bus.done0, bus.done1});
      end
      checks++; if (bus.busy !== 1'b0) begin
         errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy);
      end
      checks++; if (bus.alu_clr !== 1'b1) begin
         errors++; $display("FAIL reset_alu_clr got=%b exp=1", bus.alu_clr);
      end
      checks++; if (bus.res !== 16'h0000) begin
         errors++; $display("FAIL reset_res got=%h exp=0000", bus.res);
      end
      checks++; if ({bus.alu_a, bus.alu_b, bus.alufs} !== 34'h0) begin
         errors++; $display("FAIL reset_operands got=%h/%h/%b exp=0/0/00", bus.alu_a, bus.alu_b, bus.alufs);
      end
      checks++; if (state_dbg !== 2'd0) begin
         errors++; $display("FAIL reset_state got=%0d exp=0", state_dbg);
      end
      reset = 1'b1;
   endtask

   task automatic test_add();
      issue_op(1'b0, 2'b10, 16'h0003, 16'h0004);
      checks++; if ({o_gnt0, o_gnt1} !== 2'b10) begin
         errors++; $display("FAIL add_gnt got=%b exp=10", {o_gnt0, o_gnt1});
      end
      checks++; if ({o_busy1, o_clr1, o_state1} !== 4'b1001) begin
         errors++; $display("FAIL add_issue_busy_clr_state got=%b exp=1001", {o_busy1, o_clr1, o_state1});
      end
      checks++; if ({o_alu_a, o_alu_b, o_alufs} !== {16'h0003, 16'h0004, 2'b10}) begin
         errors++; $display("FAIL add_alu_drive got=%h/%h/%b exp=0003/0004/10", o_alu_a, o_alu_b, o_alufs);
      end
      checks++; if ({o_done0, o_done1, o_busy2} !== 3'b101) begin
         errors++; $display("FAIL add_done got=%b exp=101", {o_done0, o_done1, o_busy2});
      end
      checks++; if (o_res !== 16'h0007) begin
         errors++; $display("FAIL add_res got=%h exp=0007", o_res);
      end
      checks++; if ({o_done0_n, o_done1_n, o_busy_n} !== 3'b000) begin
         errors++; $display("FAIL add_after got=%b exp=000", {o_done0_n, o_done1_n, o_busy_n});
      end
   endtask

   task automatic test_arith();
      bit          who_t [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic [1:0]  fs_t  [4] = '{2'b11, 2'b01, 2'b10, 2'b00};
      logic [15:0] a_t   [4] = '{16'h0000, 16'h0000, 16'hFFFF, 16'hAAAA};
      logic [15:0] b_t   [4] = '{16'h0001, 16'hFFFF, 16'h0002, 16'h1234};
      logic [15:0] exp_t [4] = '{16'hFFFF, 16'h0000, 16'h0001, 16'h1234};
      for (int i = 0; i < 4; i++) begin
         issue_op(who_t[i], fs_t[i], a_t[i], b_t[i]);
         checks++; if ({o_gnt0, o_gnt1} !== {~who_t[i], who_t[i]}) begin
            errors++; $display("FAIL arith%0d_gnt got=%b exp=%b", i, {o_gnt0, o_gnt1}, {~who_t[i], who_t[i]});
         end
         checks++; if ({o_done0, o_done1} !== {~who_t[i], who_t[i]}) begin
            errors++; $display("FAIL arith%0d_done got=%b exp=%b", i, {o_done0, o_done1}, {~who_t[i], who_t[i]});
         end
         checks++; if (o_res !== exp_t[i]) begin
            errors++; $display("FAIL arith%0d_res got=%h exp=%h", i, o_res, exp_t[i]);
         end
      end
   endtask

   // Last result was 0x1234; ten quiet cycles must leave everything at rest.
   task automatic test_idle();
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         checks++;
         if ({bus.alu_clr, bus.busy, bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.res}
             !== {6'b100000, 16'h1234}) begin
            errors++;
            $display("FAIL idle%0d got clr=%b busy=%b g=%b%b d=%b%b res=%h exp clr=1 busy=0 g=00 d=00 res=1234",
                     k, bus.alu_clr, bus.busy, bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.res);
         end
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_v;
      logic       w;
      int         ph;
      do_reset();
      bus.req0 = 1'b1; bus.fs0 = 2'b10; bus.a0 = 16'h0001; bus.b0 = 16'h0001;
      bus.req1 = 1'b1; bus.fs1 = 2'b10; bus.a1 = 16'h0010; bus.b1 = 16'h0010;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         ph = (k - 1) % 3;
         w  = ((k - 1) / 3) % 2;
         exp_v = 4'b0000;
         if (ph == 0) exp_v = w ? 4'b0100 : 4'b1000;
         if (ph == 1) exp_v = w ? 4'b0001 : 4'b0010;
         checks++; if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1} !== exp_v) begin
            errors++; $display("FAIL rr%0d_gnt_done got=%b exp=%b",
                               k, {bus.gnt0, bus.gnt1, bus.done0, bus.done1}, exp_v);
         end
         if (ph == 1) begin
            checks++; if (bus.res !== (w ? 16'h0020 : 16'h0002)) begin
               errors++; $display("FAIL rr%0d_res got=%h exp=%h", k, bus.res, w ? 16'h0020 : 16'h0002);
            end
         end
      end
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_in_flight();
      bus.req1 = 1'b1; bus.fs1 = 2'b10; bus.a1 = 16'h0005; bus.b1 = 16'h0006;
      @(posedge clk);
      @(negedge clk);
      checks++; if ({bus.gnt0, bus.gnt1} !== 2'b01) begin
         errors++; $display("FAIL rif_gnt1 got=%b exp=01", {bus.gnt0, bus.gnt1});
      end
      bus.req1 = 1'b0;
      #1 reset = 1'b0;
      #1;
      checks++; if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.alu_clr} !== 6'b000001) begin
         errors++; $display("FAIL rif_async got=%b exp=000001",
                            {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.alu_clr});
      end
      checks++; if ({bus.res, bus.alu_a} !== 32'h0) begin
         errors++; $display("FAIL rif_regs got=%h/%h exp=0000/0000", bus.res, bus.alu_a);
      end
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++; if ({bus.done0, bus.done1, bus.busy} !== 3'b000) begin
            errors++; $display("FAIL rif_no_done%0d got=%b exp=000", k, {bus.done0, bus.done1, bus.busy});
         end
      end
      bus.req0 = 1'b1; bus.fs0 = 2'b10; bus.a0 = 16'h0001; bus.b0 = 16'h0001;
      bus.req1 = 1'b1; bus.fs1 = 2'b10; bus.a1 = 16'h0010; bus.b1 = 16'h0010;
      @(posedge clk);
      @(negedge clk);
      checks++; if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
         errors++; $display("FAIL rif_next_gnt got=%b exp=10", {bus.gnt0, bus.gnt1});
      end
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      @(negedge clk);
      checks++; if ({bus.done0, bus.done1, bus.res} !== {2'b10, 16'h0002}) begin
         errors++; $display("FAIL rif_next_done got=%b res=%h exp=10 res=0002", {bus.done0, bus.done1}, bus.res);
      end
      @(negedge clk);
   endtask

   initial begin
      reset    = 1'b0;
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      bus.fs0  = 2'b00; bus.fs1 = 2'b00;
      bus.a0   = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
      test_reset();
      @(negedge clk);
      test_add();
      test_arith();
      test_idle();
      test_round_robin();
      test_reset_in_flight();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width; only 16 is supported with the team's alu16 datapath.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports req0, req1  input  1 each  operation request from requester 0 / 1.
REQ-005 SHALL have ports fs0, fs1  input  2 each  ALU function: 00=b, 01=b+1, 10=a+b, 11=a-b.
REQ-006 SHALL have ports a0, b0, a1, b1  input  WIDTH each  operands of requester 0 / 1.
REQ-007 SHALL have ports gnt0, gnt1  output  1 each  one-cycle grant pulse (operands captured).
REQ-008 SHALL have ports done0, done1  output  1 each  one-cycle completion pulse; res valid that cycle.
REQ-009 SHALL have port res  output  WIDTH  registered result, held until next completion.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have ports alu_a, alu_b  output  WIDTH each  operands to ALU (from operand registers).
REQ-012 SHALL have port alufs  output  2  function select to ALU (from function register).
REQ-013 SHALL have port alu_clr  output  1  drives ALU reset input; high forces ALU sum to 0.
REQ-014 SHALL have port alu_in  input  WIDTH  combinational ALU result.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, WB; IDLE->ISSUE when req0|req1 sampled high; ISSUE->WB unconditionally; WB->IDLE unconditionally.
REQ-016 SHALL sample req0/req1 only in IDLE; requests in ISSUE/WB are ignored, not queued.
REQ-017 SHALL choose the winner in IDLE: single requester wins; if both, the one indicated by priority pointer prio wins.
REQ-018 SHALL, on the IDLE->ISSUE edge, load op_a, op_b, op_fs from the winner and record winner id.
REQ-019 SHALL assert gnt of the winner for exactly the ISSUE cycle; requester may drop req/operands after gnt.
REQ-020 SHALL in ISSUE drive alu_a=op_a, alu_b=op_b, alufs=op_fs, alu_clr=0.
REQ-021 SHALL drive alu_clr=1 in IDLE and WB; alu_a, alu_b, alufs hold operand registers in all states.
REQ-022 SHALL on the ISSUE->WB edge load res <= alu_in.
REQ-023 SHALL assert done of the recorded winner for exactly the WB cycle; never both done0 and done1.
REQ-024 SHALL on the WB->IDLE edge set prio to the non-winner (round-robin).
REQ-025 SHALL give fixed latency: request sampled in cycle N -> gnt in N+1 -> done/res in N+2; max throughput one op per 3 cycles.
REQ-026 SHALL treat arithmetic as modulo 2^WIDTH; no carry/overflow output; wrap is not an error.
REQ-027 SHALL never assert gnt0 and gnt1 in the same cycle.

Reset
REQ-028 SHALL on reset low, asynchronously: state=IDLE, prio=0, op_a=op_b=0, op_fs=00, res=0, gnt0=gnt1=done0=done1=0, busy=0, alu_clr=1.
REQ-029 SHALL discard an in-flight operation on reset in ISSUE or WB; no done pulse follows.
REQ-030 SHALL resume arbitration the first rising edge after reset deasserts, with requester 0 priority.

Verification
REQ-031 SHALL pass: req0, fs0=10, a0=0x0003, b0=0x0004 in IDLE cycle N -> gnt0 at N+1, done0 and res=0x0007 at N+2, busy high N+1..N+2.
REQ-032 SHALL pass: after reset req0 and req1 held high together -> first grant gnt0, second gnt1 three cycles later, alternating thereafter.
REQ-033 SHALL pass: fs=11, a=0x0000, b=0x0001 -> res=0xFFFF; fs=01, b=0xFFFF -> res=0x0000.
REQ-034 SHALL pass: reset low during ISSUE of a req1 op -> outputs at reset values immediately, no done1, next simultaneous request granted to req0.
REQ-035 SHALL pass: no requests for 10 cycles -> alu_clr=1, busy=0, no gnt/done pulses, res unchanged.
